// File: rtl/timetag_cmd_pkg.sv
// ---------------------------------------------------------------------------
// timetag_cmd_pkg
// Shared definitions for the timetag host command decoder: opcode and
// control-target byte values, decoder state encoding, error codes, and a
// helper that checks a register-write length byte.
// ---------------------------------------------------------------------------
package timetag_cmd_pkg;

    // Frame opcodes (first byte of every frame)
    localparam logic [7:0] OP_CTRL  = 8'h01;
    localparam logic [7:0] OP_REGWR = 8'h05;

    // Control-write targets
    localparam logic [7:0] TGT_DETECTORS  = 8'h01;
    localparam logic [7:0] TGT_SEQUENCERS = 8'h02;

    // Error codes reported with err
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_OPCODE  = 2'd1;
    localparam logic [1:0] ERR_LENGTH  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CTRL_TGT = 3'd1,
        ST_CTRL_VAL = 3'd2,
        ST_REG_LEN  = 3'd3,
        ST_REG_DATA = 3'd4,
        ST_REG_ADDR = 3'd5
    } state_e;

    // A length byte is usable when it names 1..max_len data bytes.
    function automatic logic len_valid(input logic [7:0] len, input int unsigned max_len);
        return (len != 8'd0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/cmd_parser_if.sv
// ---------------------------------------------------------------------------
// cmd_parser_if
// Byte-stream input and decoded-strobe outputs of the command parser.
//   master : command source / consumer side (drives cmd_wr, cmd_in)
//   slave  : the parser (drives strobes, payloads, busy, err)
// Signals:
//   cmd_wr/cmd_in           byte valid + byte
//   reg_wr/reg_addr/reg_data register-write strobe and payload
//   ctrl_wr/ctrl_target/ctrl_value control-write strobe and payload
//   busy                    frame partially received
//   err/err_code            error strobe and reason
// ---------------------------------------------------------------------------
interface cmd_parser_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              cmd_wr;
    logic [7:0]        cmd_in;
    logic              reg_wr;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_data;
    logic              ctrl_wr;
    logic [7:0]        ctrl_target;
    logic [7:0]        ctrl_value;
    logic              busy;
    logic              err;
    logic [1:0]        err_code;

    modport master (
        output cmd_wr, cmd_in,
        input  reg_wr, reg_addr, reg_data, ctrl_wr, ctrl_target, ctrl_value,
               busy, err, err_code
    );

    modport slave (
        input  cmd_wr, cmd_in,
        output reg_wr, reg_addr, reg_data, ctrl_wr, ctrl_target, ctrl_value,
               busy, err, err_code
    );
endinterface

// File: rtl/cmd_timeout_counter.sv
// ---------------------------------------------------------------------------
// cmd_timeout_counter
// Counts idle cycles inside a partially received frame.
//   clk, reset_n : clock, synchronous active-low reset
//   clear_i      : zero the count (byte accepted or no frame in progress)
//   enable_i     : count this cycle
//   expired_o    : this cycle's count would reach TIMEOUT
// expired_o is asserted on the TIMEOUT-th consecutive enabled cycle, so the
// parser can act on the same edge that would complete the count.
// ---------------------------------------------------------------------------
module cmd_timeout_counter #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int             CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, wrap to zero on expiry, otherwise increment or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign expired_o = enable_i && !clear_i && (cnt_q == LAST);

    // Count register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/cmd_parser.sv
// ---------------------------------------------------------------------------
// cmd_parser
// Decodes the host command byte stream into one-cycle register-write and
// control-write strobes.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : cmd_wr/cmd_in in; reg_wr/reg_addr/reg_data,
//                  ctrl_wr/ctrl_target/ctrl_value, busy, err/err_code out
// Frames: 01 tgt val          -> ctrl write
//         05 len d[len] addr  -> reg write (data MSB first, zero-extended)
// Strobes and err are registered and appear the cycle after the edge that
// samples the final byte. Payload outputs only change together with their
// strobe, so partial frames are staged internally.
// ---------------------------------------------------------------------------
module cmd_parser
    import timetag_cmd_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int MAX_LEN = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    cmd_parser_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    state_e            state_q;
    logic [CNT_W-1:0]  len_q;
    logic [DATA_W-1:0] shift_q;
    logic [7:0]        tgt_stage_q;
    logic              reg_wr_q;
    logic [ADDR_W-1:0] reg_addr_q;
    logic [DATA_W-1:0] reg_data_q;
    logic              ctrl_wr_q;
    logic [7:0]        ctrl_target_q;
    logic [7:0]        ctrl_value_q;
    logic              err_q;
    logic [1:0]        err_code_q;

    logic [DATA_W-1:0] shift_d;
    logic              tmo_clear;
    logic              tmo_en;
    logic              tmo_expired;

    assign shift_d   = {shift_q[DATA_W-9:0], bus.cmd_in};
    assign tmo_clear = bus.cmd_wr || (state_q == ST_IDLE);
    assign tmo_en    = (state_q != ST_IDLE) && !bus.cmd_wr;

    cmd_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (tmo_clear),
        .enable_i  (tmo_en),
        .expired_o (tmo_expired)
    );

    // Frame decoder FSM with registered strobes and payloads.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            shift_q       <= '0;
            tgt_stage_q   <= 8'h00;
            reg_wr_q      <= 1'b0;
            reg_addr_q    <= '0;
            reg_data_q    <= '0;
            ctrl_wr_q     <= 1'b0;
            ctrl_target_q <= 8'h00;
            ctrl_value_q  <= 8'h00;
            err_q         <= 1'b0;
            err_code_q    <= ERR_NONE;
        end else begin
            reg_wr_q  <= 1'b0;
            ctrl_wr_q <= 1'b0;
            err_q     <= 1'b0;
            // An arriving byte always beats a timeout expiring on the same edge.
            if (bus.cmd_wr) begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.cmd_in == OP_CTRL) begin
                            state_q <= ST_CTRL_TGT;
                        end else if (bus.cmd_in == OP_REGWR) begin
                            state_q <= ST_REG_LEN;
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_OPCODE;
                        end
                    end
                    ST_CTRL_TGT: begin
                        tgt_stage_q <= bus.cmd_in;
                        state_q     <= ST_CTRL_VAL;
                    end
                    ST_CTRL_VAL: begin
                        ctrl_target_q <= tgt_stage_q;
                        ctrl_value_q  <= bus.cmd_in;
                        ctrl_wr_q     <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                    ST_REG_LEN: begin
                        if (len_valid(bus.cmd_in, MAX_LEN)) begin
                            len_q   <= CNT_W'(bus.cmd_in);
                            shift_q <= '0;
                            state_q <= ST_REG_DATA;
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_LENGTH;
                            state_q    <= ST_IDLE;
                        end
                    end
                    ST_REG_DATA: begin
                        shift_q <= shift_d;
                        len_q   <= len_q - CNT_W'(1);
                        if (len_q == CNT_W'(1)) begin
                            state_q <= ST_REG_ADDR;
                        end
                    end
                    ST_REG_ADDR: begin
                        reg_addr_q <= ADDR_W'(bus.cmd_in);
                        reg_data_q <= shift_q;
                        reg_wr_q   <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end else if (tmo_expired) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_TIMEOUT;
                state_q    <= ST_IDLE;
            end
        end
    end

    assign bus.reg_wr      = reg_wr_q;
    assign bus.reg_addr    = reg_addr_q;
    assign bus.reg_data    = reg_data_q;
    assign bus.ctrl_wr     = ctrl_wr_q;
    assign bus.ctrl_target = ctrl_target_q;
    assign bus.ctrl_value  = ctrl_value_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.err         = err_q;
    assign bus.err_code    = err_code_q;
endmodule

// File: doc/cmd_parser.md
Name: cmd_parser

Overview:
- Receive-side decoder for the host command byte stream (cmd_in/cmd_wr) written by the FX2 interface into the timetag core.
- Reassembles framed commands into one-cycle register-write and control-write strobes for the pulse sequencers and detector channels.
- Resynchronises on malformed frames and reports errors.
- Sits between the command byte path and the register file / control logic inside timetag.

Parameters:
- DATA_W, 32, width of assembled register data
- ADDR_W, 8, width of register address
- MAX_LEN, 4, maximum data bytes per register write (DATA_W/8)
- TIMEOUT, 1024, idle clk cycles mid-frame before the frame is abandoned

Ports:
- clk  in  1  core clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- cmd_wr  in  1  byte valid; one byte accepted per clk cycle while high
- cmd_in  in  8  command byte
- reg_wr  out  1  one-cycle strobe: register write
- reg_addr  out  ADDR_W  register address, valid with reg_wr
- reg_data  out  DATA_W  register data, valid with reg_wr
- ctrl_wr  out  1  one-cycle strobe: control write
- ctrl_target  out  8  control target (0x01 detectors, 0x02 pulse sequencers)
- ctrl_value  out  8  control value (bit0 = enable)
- busy  out  1  high while a frame is partially received
- err  out  1  one-cycle error strobe
- err_code  out  2  valid with err: 1 bad opcode, 2 bad length, 3 timeout

Behaviour:
- Frame formats:
  - Control write: 0x01, target, value.
  - Register write: 0x05, len, len data bytes MSB first, addr.
  - Example: 05 04 00 00 00 40 02 writes 0x00000040 to address 0x02.
- States: IDLE, CTRL_TGT, CTRL_VAL, REG_LEN, REG_DATA, REG_ADDR.
- Transitions advance only on cycles with cmd_wr=1. A cycle without cmd_wr holds state.
- IDLE:
  - 0x01 -> CTRL_TGT.
  - 0x05 -> REG_LEN.
  - Any other byte -> err=1, err_code=1, stay IDLE. The byte is discarded.
- CTRL_TGT: latch target -> CTRL_VAL.
- CTRL_VAL: latch value -> IDLE; ctrl_wr=1 on the next cycle.
- REG_LEN:
  - len in 1..MAX_LEN: load byte counter, clear data shift register -> REG_DATA.
  - len = 0 or len > MAX_LEN: err=1, err_code=2 -> IDLE.
- REG_DATA:
  - Each byte: data = (data << 8) | byte; decrement counter.
  - When the counter reaches 0 -> REG_ADDR.
  - Short lengths are zero-extended; e.g. len=1 with byte 0x7F gives 0x0000007F.
- REG_ADDR: latch address -> IDLE; reg_wr=1 on the next cycle.
- Latency: strobe asserted exactly 1 cycle after the edge sampling the final byte. Address/data/target/value are held stable until the next strobe.
- Back-to-back: the opcode of the next frame may arrive in the cycle right after the final byte. No gap is required and no byte is lost.
- busy = (state != IDLE).
- Timeout:
  - Counter resets on every accepted byte and counts while busy and cmd_wr=0.
  - On reaching TIMEOUT: err=1, err_code=3 -> IDLE; partial frame discarded.
  - If cmd_wr=1 arrives in the same cycle the count would expire, the byte wins: it is accepted and the counter is cleared.
- err and a strobe never coincide.
- Reset (reset_n low at a clk edge, including mid-frame):
  - state=IDLE; all strobes, err, busy = 0.
  - reg_addr, reg_data, ctrl_target, ctrl_value, err_code = 0.
  - Timeout counter = 0.
  - cmd_wr during reset is ignored.

Decomposition:
- Package timetag_cmd_pkg holds:
  - opcode constants OP_CTRL=0x01, OP_REGWR=0x05
  - target constants TGT_DETECTORS=0x01, TGT_SEQUENCERS=0x02
  - state enum
  - error code constants
- One sub-module: cmd_timeout_counter (clear, enable, expired), parameterised by TIMEOUT.
- Everything else stays in cmd_parser.

Test Plan:
- Reg write: stream 05 04 00 00 00 40 02 on consecutive cycles -> exactly one reg_wr, reg_addr=0x02, reg_data=0x00000040, 1 cycle after the last byte; err never asserted.
- Three back-to-back frames with no gaps: addr 02/data 0x40, addr 04/data 0x20, addr 08/data 0x10 -> three reg_wr pulses with those values in order.
- Control writes: 01 01 01 then 01 02 01 -> ctrl_wr twice, (target 0x01, value 0x01) then (0x02, 0x01).
- Gapped bytes: same 05 frame with cmd_wr low 3 cycles between each byte (TIMEOUT=1024) -> identical single reg_wr result, busy high throughout the frame.
- Errors:
  - Byte 0x33 in IDLE -> err, code 1.
  - 05 00 -> err, code 2, then the following valid 01 01 01 is decoded normally.
  - 05 04 00 then silence with TIMEOUT=16 -> err, code 3, exactly 16 cycles after the last byte; busy falls.
- Reset: assert reset_n=0 for 1 cycle after 05 04 00 00 -> no reg_wr; a following full frame decodes correctly; all outputs 0 during reset.
